// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between mem_access_ctrl and a synchronous RAM.
//   master : controller side, drives address/enables/byte enables/write data, receives q.
//   slave  : memory side, the reverse.
// Signals:
//   mem_address  doubleword address (ADDR_W bits)
//   mem_clken    memory clock enable
//   mem_rden     read enable
//   mem_wren     write enable
//   mem_byteena  per-byte write enables
//   mem_data     write data, already placed on its byte lanes
//   mem_q        read data, returned RD_LATENCY cycles after mem_rden
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_clken;
    logic              mem_rden;
    logic              mem_wren;
    logic [7:0]        mem_byteena;
    logic [63:0]       mem_data;
    logic [63:0]       mem_q;

    modport master (
        output mem_address, mem_clken, mem_rden, mem_wren, mem_byteena, mem_data,
        input  mem_q
    );

    modport slave (
        input  mem_address, mem_clken, mem_rden, mem_wren, mem_byteena, mem_data,
        output mem_q
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns a pipeline load/store request into
// data-memory control, stalls the pipeline while a load waits for the RAM,
// and extracts/extends the loaded lane.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   MemReadEnM      load request
//   MemWriteEnM     store request
//   MemSizeM        00 byte, 01 half, 10 word, 11 double
//   LoadUnsignedM   1 zero-extend, 0 sign-extend the load result
//   ALUResultM      byte address
//   ReadData2M      store data, right-aligned
//   StallM          hold IF/ID/EX/MEM pipeline registers
//   LoadValidM      ReadDataM is valid this cycle
//   ReadDataM       extended load result (held between loads)
//   AccessErrM      misaligned or read+write request (IDLE only)
//   mem             data-memory bus (master modport)
module mem_access_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemReadEnM,
    input  logic                      MemWriteEnM,
    input  logic [1:0]                MemSizeM,
    input  logic                      LoadUnsignedM,
    input  logic [63:0]               ALUResultM,
    input  logic [63:0]               ReadData2M,
    output logic                      StallM,
    output logic                      LoadValidM,
    output logic [63:0]               ReadDataM,
    output logic                      AccessErrM,
    mem_access_ctrl_if.master         mem
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        rdata_q, rdata_d;

    logic [2:0]         off;
    logic               misaligned;
    logic               err;
    logic               in_idle;
    logic               ld_ok;
    logic               st_ok;
    logic [7:0]         be_base;
    logic [63:0]        shifted;
    logic [63:0]        extracted;
    logic               unused_addr_hi;

    assign off            = ALUResultM[2:0];
    assign unused_addr_hi = ^ALUResultM[63:ADDR_W+3];

    always_comb begin
        misaligned = 1'b0;
        be_base    = 8'h01;
        case (MemSizeM)
            2'b00: begin misaligned = 1'b0;        be_base = 8'h01; end
            2'b01: begin misaligned = off[0];      be_base = 8'h03; end
            2'b10: begin misaligned = |off[1:0];   be_base = 8'h0F; end
            default: begin misaligned = |off;      be_base = 8'hFF; end
        endcase
    end

    assign err     = ((MemReadEnM | MemWriteEnM) & misaligned) | (MemReadEnM & MemWriteEnM);
    assign in_idle = (state_q == IDLE);
    // Requests are only acted on in IDLE and never while reset is asserted.
    assign ld_ok   = rst & in_idle & MemReadEnM  & ~err;
    assign st_ok   = rst & in_idle & MemWriteEnM & ~err;

    // Load lane extraction: the addressed byte lands at bit 0 before extension.
    assign shifted = mem.mem_q >> {off, 3'b000};

    always_comb begin
        extracted = shifted;
        case (MemSizeM)
            2'b00: extracted = LoadUnsignedM ? {56'b0, shifted[7:0]}
                                             : {{56{shifted[7]}}, shifted[7:0]};
            2'b01: extracted = LoadUnsignedM ? {48'b0, shifted[15:0]}
                                             : {{48{shifted[15]}}, shifted[15:0]};
            2'b10: extracted = LoadUnsignedM ? {32'b0, shifted[31:0]}
                                             : {{32{shifted[31]}}, shifted[31:0]};
            default: extracted = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (ld_ok) begin
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d = extracted;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign StallM      = ld_ok | (rst & (state_q == RD_WAIT));
    assign LoadValidM  = rst & (state_q == DONE);
    assign AccessErrM  = rst & in_idle & err;
    assign ReadDataM   = rdata_q;

    assign mem.mem_clken   = rst;
    assign mem.mem_address = ALUResultM[ADDR_W+2:3];
    assign mem.mem_rden    = ld_ok;
    assign mem.mem_wren    = st_ok;
    assign mem.mem_byteena = st_ok ? (be_base << off) : '0;
    assign mem.mem_data    = ReadData2M << {off, 3'b000};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: DUT 0 built with RD_LATENCY=2, DUT 1 with
// RD_LATENCY=1. Only the DUT selected by 'cur' receives requests. A byte-array
// reference memory predicts load results; a RAM model with latency serves mem_q.
module tb_mem_access_ctrl;

    localparam int K_LD = 0;
    localparam int K_ST = 1;
    localparam int K_ER = 2;

    typedef struct {
        int          kind;
        logic [9:0]  addr;
        logic [7:0]  be;
        logic [63:0] data;
        bit          b2b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en [2];
    logic        wr_en [2];
    logic [1:0]  size_i;
    logic        lu_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;

    logic        stall_s  [2];
    logic        lvalid_s [2];
    logic [63:0] rdata_s  [2];
    logic        aerr_s   [2];
    logic        rden_s   [2];
    logic        wren_s   [2];
    logic        clken_s  [2];
    logic [7:0]  be_s     [2];
    logic [63:0] mdata_s  [2];
    logic [9:0]  maddr_s  [2];
    logic [63:0] q_s      [2];

    logic [63:0] ram [2][32];
    logic [63:0] p0  [2];
    logic [63:0] p1  [2];
    logic [7:0]  refm [2][256];

    ev_t         evq [$];
    logic [63:0] ldq [$];

    int          cur = 0;
    int          cyc = 0;
    logic        rst_q;
    int          tests = 0;
    int          fails = 0;
    int          run = 0;
    int          issue_cyc = 0;
    int          done_cyc = -10;
    logic [63:0] hold_exp = '0;
    bit          end_req = 0;
    bit          done = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_ctrl_if #(.ADDR_W(10)) mif ();
        mem_access_ctrl #(.ADDR_W(10), .RD_LATENCY(g == 0 ? 2 : 1)) dut (
            .clk(clk), .rst(rst),
            .MemReadEnM(rd_en[g]), .MemWriteEnM(wr_en[g]),
            .MemSizeM(size_i), .LoadUnsignedM(lu_i),
            .ALUResultM(addr_i), .ReadData2M(wdata_i),
            .StallM(stall_s[g]), .LoadValidM(lvalid_s[g]),
            .ReadDataM(rdata_s[g]), .AccessErrM(aerr_s[g]),
            .mem(mif)
        );
        assign mif.mem_q   = q_s[g];
        assign rden_s[g]   = mif.mem_rden;
        assign wren_s[g]   = mif.mem_wren;
        assign clken_s[g]  = mif.mem_clken;
        assign be_s[g]     = mif.mem_byteena;
        assign mdata_s[g]  = mif.mem_data;
        assign maddr_s[g]  = mif.mem_address;
    end

    assign q_s[0] = p1[0];
    assign q_s[1] = p0[1];

    function automatic logic [7:0] init_byte(int d, int i);
        return 8'(i * 37 + 11 + d * 91);
    endfunction

    // RAM model: initial contents loaded during reset, byte-enabled writes,
    // read data shifted through a pipeline; garbage when no read was issued.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
        for (int g = 0; g < 2; g++) begin
            if (!rst) begin
                for (int w = 0; w < 32; w++)
                    for (int k = 0; k < 8; k++)
                        ram[g][w][8*k +: 8] <= init_byte(g, 8 * w + k);
            end else if (wren_s[g]) begin
                for (int b = 0; b < 8; b++)
                    if (be_s[g][b])
                        ram[g][maddr_s[g][4:0]][8*b +: 8] <= mdata_s[g][8*b +: 8];
            end
            p0[g] <= rden_s[g] ? ram[g][maddr_s[g][4:0]] : {$urandom, $urandom};
            p1[g] <= p0[g];
        end
    end

    task automatic ref_init();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                refm[d][i] = init_byte(d, i);
    endtask

    function automatic logic [63:0] ref_load(int d, int a, int sz, bit lu);
        int          n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (64'(refm[d][a + i]) << (8 * i));
        if (!lu && n < 8 && v[8 * n - 1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic set_addr(int a);
        addr_i = {51'({$urandom, $urandom}), 5'b0, 8'(a)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(int a, int sz, bit lu, bit b2b);
        ev_t e;
        set_addr(a);
        size_i = 2'(sz);
        lu_i   = lu;
        rd_en[cur] = 1'b1;
        wr_en[cur] = 1'b0;
        e.kind = K_LD; e.addr = 10'(a >> 3); e.be = '0; e.data = '0; e.b2b = b2b;
        evq.push_back(e);
        ldq.push_back(ref_load(cur, a, sz, lu));
        step();
        for (int i = 0; i < 8; i++) begin
            if (!stall_s[cur]) break;
            step();
        end
        step();
        rd_en[cur] = 1'b0;
    endtask

    task automatic do_store(int a, int sz, logic [63:0] wd);
        ev_t         e;
        int          n;
        int          off;
        logic [15:0] t16;
        n   = 1 << sz;
        off = a % 8;
        t16 = ((16'd1 << n) - 16'd1) << off;
        e.kind = K_ST; e.addr = 10'(a >> 3); e.be = t16[7:0];
        e.data = wd << (8 * off); e.b2b = 0;
        evq.push_back(e);
        for (int i = 0; i < n; i++)
            refm[cur][a + i] = wd[8*i +: 8];
        set_addr(a);
        size_i  = 2'(sz);
        wdata_i = wd;
        wr_en[cur] = 1'b1;
        step();
        wr_en[cur] = 1'b0;
    endtask

    task automatic do_err(bit rd, bit wr, int a, int sz);
        ev_t e;
        e.kind = K_ER; e.addr = '0; e.be = '0; e.data = '0; e.b2b = 0;
        evq.push_back(e);
        set_addr(a);
        size_i  = 2'(sz);
        wdata_i = {$urandom, $urandom};
        rd_en[cur] = rd;
        wr_en[cur] = wr;
        step();
        rd_en[cur] = 1'b0;
        wr_en[cur] = 1'b0;
    endtask

    task automatic do_reset_with_load(int a, int sz);
        rst = 1'b0;
        ref_init();
        set_addr(a);
        size_i = 2'(sz);
        lu_i   = 1'b0;
        rd_en[cur] = 1'b1;
        step();
        step();
        rst = 1'b1;
        do_load(a, sz, 1'b0, 1'b0);
    endtask

    task automatic load_abort(int a, int sz);
        ev_t e;
        e.kind = K_LD; e.addr = 10'(a >> 3); e.be = '0; e.data = '0; e.b2b = 0;
        evq.push_back(e);
        set_addr(a);
        size_i = 2'(sz);
        rd_en[cur] = 1'b1;
        step();
        rst = 1'b0;
        rd_en[cur] = 1'b0;
        ref_init();
        step();
        rst = 1'b1;
        repeat (5) step();
    endtask

    task automatic random_ops(int count);
        bit prev_load;
        int r, a, sz;
        prev_load = 0;
        for (int k = 0; k < count; k++) begin
            r  = $urandom_range(0, 99);
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, 255);
            if (r < 40) begin
                a = a & ~((1 << sz) - 1);
                do_load(a, sz, 1'($urandom), prev_load);
                prev_load = 1;
            end else if (r < 75) begin
                a = a & ~((1 << sz) - 1);
                do_store(a, sz, {$urandom, $urandom});
                prev_load = 0;
            end else if (r < 90) begin
                if (r < 85) begin
                    sz = $urandom_range(1, 3);
                    if (a % (1 << sz) == 0) a = a | 1;
                    if (r < 80) do_err(1'b1, 1'b0, a, sz);
                    else        do_err(1'b0, 1'b1, a, sz);
                end else begin
                    do_err(1'b1, 1'b1, a, sz);
                end
                prev_load = 0;
            end else begin
                step();
                prev_load = 0;
            end
        end
    endtask

    // Monitor: pops expectations whenever the selected DUT presents an operation.
    always @(negedge clk) begin
        int          d;
        int          lat;
        ev_t         e;
        logic [63:0] x;
        bit          ok;
        d   = cur;
        lat = (d == 0) ? 2 : 1;
        if (end_req && !done) begin
            tests++;
            if (evq.size() != 0 || ldq.size() != 0) begin
                fails++;
                $display("FAIL drain: %0d ops and %0d loads outstanding, required 0 and 0",
                         evq.size(), ldq.size());
            end
            done = 1;
        end else if (rst === 1'b0) begin
            tests++;
            ok = !stall_s[d] && !rden_s[d] && !wren_s[d] && !aerr_s[d] && !lvalid_s[d] && !clken_s[d];
            if (rst_q === 1'b0) ok = ok && (rdata_s[d] == 64'd0);
            if (!ok) begin
                fails++;
                $display("FAIL reset: stall=%b rden=%b wren=%b err=%b valid=%b clken=%b rdata=%h, required all 0",
                         stall_s[d], rden_s[d], wren_s[d], aerr_s[d], lvalid_s[d], clken_s[d], rdata_s[d]);
            end
            run      = 0;
            hold_exp = '0;
        end else if (rst === 1'b1) begin
            tests++;
            if (clken_s[d] !== 1'b1) begin
                fails++;
                $display("FAIL clken: got %b required 1", clken_s[d]);
            end
            if (aerr_s[d] || wren_s[d] || rden_s[d]) begin
                tests++;
                if (evq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_op: err=%b wren=%b rden=%b, required none", aerr_s[d], wren_s[d], rden_s[d]);
                end else begin
                    e = evq.pop_front();
                    if (aerr_s[d])
                        ok = (e.kind == K_ER) && !rden_s[d] && !wren_s[d] && !stall_s[d];
                    else if (wren_s[d])
                        ok = (e.kind == K_ST) && !rden_s[d] && !stall_s[d] && (be_s[d] == e.be)
                             && (mdata_s[d] == e.data) && (maddr_s[d] == e.addr);
                    else begin
                        ok = (e.kind == K_LD) && stall_s[d] && (maddr_s[d] == e.addr)
                             && (!e.b2b || cyc == done_cyc + 1);
                        issue_cyc = cyc;
                    end
                    if (!ok) begin
                        fails++;
                        $display("FAIL op: got err=%b wren=%b rden=%b stall=%b be=%h data=%h addr=%h cyc=%0d, required kind=%0d be=%h data=%h addr=%h b2b=%0d after done at %0d",
                                 aerr_s[d], wren_s[d], rden_s[d], stall_s[d], be_s[d], mdata_s[d], maddr_s[d], cyc,
                                 e.kind, e.be, e.data, e.addr, e.b2b, done_cyc);
                    end
                end
            end
            if (stall_s[d]) run++;
            if (run > lat + 1) begin
                tests++;
                fails++;
                $display("FAIL stall_len: got %0d cycles, required %0d", run, lat + 1);
                run = 0;
            end
            tests++;
            if (lvalid_s[d]) begin
                if (ldq.size() == 0) begin
                    fails++;
                    $display("FAIL load_valid: got LoadValidM=1, required 0");
                end else begin
                    x = ldq.pop_front();
                    if (rdata_s[d] != x || run != lat + 1 || cyc != issue_cyc + lat + 1 || stall_s[d]) begin
                        fails++;
                        $display("FAIL load: got data=%h stall_cycles=%0d latency=%0d stall=%b, required data=%h stall_cycles=%0d latency=%0d stall=0",
                                 rdata_s[d], run, cyc - issue_cyc, stall_s[d], x, lat + 1, lat + 1);
                    end
                    hold_exp = x;
                end
                done_cyc = cyc;
                run      = 0;
            end else begin
                if (rdata_s[d] != hold_exp) begin
                    fails++;
                    $display("FAIL hold: got %h required %h", rdata_s[d], hold_exp);
                end
                if (!stall_s[d]) run = 0;
            end
        end
    end

    initial begin
        rst      = 1'b0;
        rd_en[0] = 1'b0; rd_en[1] = 1'b0;
        wr_en[0] = 1'b0; wr_en[1] = 1'b0;
        size_i   = 2'b00;
        lu_i     = 1'b0;
        addr_i   = '0;
        wdata_i  = '0;

        cur = 0;
        do_reset_with_load(8'h40, 3);
        do_store(8'h13, 0, 64'hAB);
        do_store(8'h10, 2, 64'h8000_0000);
        do_load(8'h13, 0, 1'b0, 1'b0);
        do_store(8'h06, 1, 64'h8001);
        do_load(8'h06, 1, 1'b1, 1'b0);
        do_load(8'h08, 3, 1'b0, 1'b1);
        do_err(1'b1, 1'b0, 8'h06, 2);
        do_err(1'b0, 1'b1, 8'h01, 1);
        do_err(1'b1, 1'b1, 8'h10, 3);
        load_abort(8'h20, 2);
        random_ops(150);

        step();
        cur = 1;
        do_reset_with_load(8'h18, 2);
        do_load(8'h18, 2, 1'b0, 1'b1);
        do_load(8'h24, 2, 1'b1, 1'b1);
        random_ops(80);

        step();
        end_req = 1;
        for (int i = 0; i < 10 && !done; i++) @(posedge clk);
        if (!done) begin
            $display("FAIL monitor: drain check not reached");
            $fatal(1, "monitor stalled");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the synchronous data memory (clken/rden/wren/byteena/address/data/q) on behalf of the memory stage.
- Converts a pipeline load/store request into memory control signals:
  - byte-lane placement and byte enables for stores;
  - multi-cycle read wait with pipeline stall for loads;
  - lane extraction and sign/zero extension of load data.
- Flags misaligned or conflicting requests. Sits between the EX/MEM pipeline register and the data memory; its load result feeds the MEM/WB register.

Parameters:
- ADDR_W, 10: doubleword address width at the memory port; byte address bits [ADDR_W+2:3] select the doubleword.
- RD_LATENCY, 2: cycles from a rden cycle to valid q. Legal values are ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk).
- MemReadEnM  in  1  load request.
- MemWriteEnM  in  1  store request.
- MemSizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- LoadUnsignedM  in  1  1 = zero-extend load, 0 = sign-extend load.
- ALUResultM  in  64  byte address.
- ReadData2M  in  64  store data, right-aligned.
- StallM  out  1  hold IF/ID/EX/MEM pipeline registers.
- LoadValidM  out  1  ReadDataM valid this cycle.
- ReadDataM  out  64  extended load result.
- AccessErrM  out  1  misaligned or conflicting request this cycle.
- mem_address  out  ADDR_W  doubleword address.
- mem_clken  out  1  memory clock enable.
- mem_rden  out  1  read enable.
- mem_wren  out  1  write enable.
- mem_byteena  out  8  byte enables.
- mem_data  out  64  write data.
- mem_q  in  64  read data.

Behaviour:
- Reset (rst==0): state=IDLE, counter=0, ReadDataM=0. LoadValidM, StallM, AccessErrM, mem_rden and mem_wren are all 0.
- mem_clken = rst. mem_address = ALUResultM[ADDR_W+2:3] at all times (the request is held stable while stalled).
- Byte offset off = ALUResultM[2:0].
- Alignment rules:
  - byte: always aligned.
  - half: off[0]==0.
  - word: off[1:0]==0.
  - double: off==0.
- Error condition: err = (MemReadEnM|MemWriteEnM) & misaligned, or MemReadEnM&MemWriteEnM.
  - AccessErrM is combinational and asserts only in IDLE.
  - On err: no rden/wren, no stall, stay IDLE.
- State IDLE:
  - Valid store (combinational, single cycle, no stall):
    - mem_wren=1.
    - mem_byteena = {01,03,0F,FF}[MemSizeM] << off.
    - mem_data = ReadData2M << 8*off (bits shifted past 63 discarded).
    - Next state IDLE.
  - Valid load:
    - mem_rden=1, StallM=1.
    - counter <= RD_LATENCY-1.
    - Next state RD_WAIT.
  - When neither request is valid: all enables 0, byteena 00.
- State RD_WAIT:
  - StallM=1, mem_rden=0, mem_wren=0.
  - If counter != 0: decrement.
  - If counter == 0: capture mem_q and go to DONE.
    - Capture rule: ReadDataM <= ext((mem_q >> 8*off) truncated to size).
    - ext: zero-extend if LoadUnsignedM, else sign-extend from the top bit of the size.
    - Double size: no extension.
- State DONE:
  - StallM=0, LoadValidM=1, ReadDataM holds the captured value.
  - Pipeline advances on this edge; next state is unconditionally IDLE.
  - Any request present in this cycle is not evaluated (it is the completing load).
- Load timing: issue cycle t (IDLE), q sampled at t+RD_LATENCY, DONE at t+RD_LATENCY+1.
  - StallM high for exactly RD_LATENCY+1 cycles per load.
- ReadDataM holds its last value between loads.
- Back-to-back loads: the second load issues in the IDLE cycle after DONE. No overlap.
- Reset mid-RD_WAIT or mid-DONE: abort to IDLE, drop the result, ReadDataM=0. Late mem_q is ignored.
- No request can arrive during RD_WAIT because the pipeline is stalled. Inputs in RD_WAIT are ignored except ALUResultM[2:0], MemSizeM and LoadUnsignedM, which are used for extraction.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 two cycles with MemReadEnM=1.
  - Response: StallM=0, mem_rden=0, ReadDataM=0, mem_clken=0. Release: the load issues on the first cycle with rst=1.
- Byte store:
  - Stimulus: SB addr 0x13, data 0xAB.
  - Response: same cycle mem_wren=1, mem_address=0x2, mem_byteena=0x08, mem_data[31:24]=0xAB, StallM=0, AccessErrM=0.
- Signed byte load (RD_LATENCY=2):
  - Stimulus: LB addr 0x13, mem_q=0x0000_0000_8000_0000 at t+2.
  - Response: StallM high t..t+2; LoadValidM=1 and ReadDataM=0xFFFF_FFFF_FFFF_FF80 at t+3; StallM=0 at t+3.
- Unsigned and double loads:
  - Stimulus: LHU addr 0x06 with mem_q[63:48]=0x8001.
  - Response: ReadDataM=0x0000_0000_0000_8001.
  - Stimulus: LD addr 0x08.
  - Response: ReadDataM=mem_q unchanged.
- Misaligned and conflicting requests:
  - Stimulus: LW addr 0x06, SH addr 0x01, and read+write together.
  - Response: each gives AccessErrM=1, mem_rden=mem_wren=0, StallM=0, state remains IDLE.
- Reset mid-load and latency variant:
  - Stimulus: rst=0 at t+1 of a load.
  - Response: next cycle StallM=0, LoadValidM never asserts, ReadDataM=0.
  - Stimulus: RD_LATENCY=1 build, back-to-back LW.
  - Response: stall 2 cycles each, second rden the cycle after the first DONE.
